// File: rtl/mmio_bridge_pkg.sv
// Shared constants and helpers for the MMIO interrupt / export-state bridge.
package mmio_bridge_pkg;

   localparam int unsigned MAX_IRQ     = 32;
   localparam int unsigned MAX_STRETCH = 255;
   localparam int unsigned MIN_SYNC    = 2;

   // Width of a counter that must hold values 0..stretch inclusive.
   function automatic int unsigned cnt_width(input int unsigned stretch);
      return $clog2(stretch + 1);
   endfunction

endpackage

// File: rtl/mmio_irq_chan.sv
// One interrupt channel: synchronizer, history flop, rising-edge detect,
// pulse-stretch counter and registered output, selectable level/edge mode.
module mmio_irq_chan
   import mmio_bridge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRETCH     = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_in,
   input  logic edge_mode,
   output logic irq_out
);

   localparam int unsigned CW = cnt_width(STRETCH);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic                   out_d;
   logic                   s;
   logic                   rise;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~hist_q;

   // Level mode follows s with the counter parked; edge mode loads/reloads on a rise
   // and keeps the output high until the count runs out.
   always_comb begin
      cnt_d = '0;
      out_d = s;
      if (edge_mode) begin
         if (rise) begin
            cnt_d = CW'(STRETCH);
            out_d = 1'b1;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            out_d = (cnt_q > CW'(1));
         end else begin
            out_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         cnt_q   <= '0;
         irq_out <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
         hist_q  <= s;
         cnt_q   <= cnt_d;
         irq_out <= out_d;
      end
   end

endmodule

// File: rtl/mmio_irq_bridge.sv
// Bridges asynchronous MMIO interrupt lines into BInterrupt and registers the
// TIE export-state bus with a changed-bit mask reported via valid/ack.
module mmio_irq_bridge
   import mmio_bridge_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 8,
   parameter int unsigned EXP_W       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRETCH     = 4
) (
   input  logic               CLK,
   input  logic               BResetN,
   input  logic [NUM_IRQ-1:0] mmio_BInterrupt,
   input  logic [NUM_IRQ-1:0] cfg_edge_mode,
   output logic [NUM_IRQ-1:0] BInterrupt,
   input  logic [EXP_W-1:0]   TIE_EXPSTATE,
   output logic [EXP_W-1:0]   EXPSTATE,
   output logic [EXP_W-1:0]   expstate_chg,
   output logic               expstate_valid,
   input  logic               expstate_ack
);

   if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
      $error("mmio_irq_bridge: NUM_IRQ must be within 1..%0d", MAX_IRQ);
   end
   if (STRETCH < 1 || STRETCH > MAX_STRETCH) begin : g_bad_stretch
      $error("mmio_irq_bridge: STRETCH must be within 1..%0d", MAX_STRETCH);
   end
   if (SYNC_STAGES < MIN_SYNC) begin : g_bad_sync
      $error("mmio_irq_bridge: SYNC_STAGES must be at least %0d", MIN_SYNC);
   end
   if (EXP_W < 1) begin : g_bad_exp_w
      $error("mmio_irq_bridge: EXP_W must be at least 1");
   end

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
      mmio_irq_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .STRETCH     (STRETCH)
      ) u_chan (
         .clk       (CLK),
         .rst_n     (BResetN),
         .irq_in    (mmio_BInterrupt[i]),
         .edge_mode (cfg_edge_mode[i]),
         .irq_out   (BInterrupt[i])
      );
   end

   logic [EXP_W-1:0] diff;
   logic [EXP_W-1:0] chg_d;
   logic             valid_d;

   assign diff = TIE_EXPSTATE ^ EXPSTATE;

   // A fresh change always wins over an ack landing in the same cycle.
   always_comb begin
      chg_d   = expstate_chg;
      valid_d = expstate_valid;
      if (diff != '0) begin
         chg_d   = expstate_ack ? diff : (expstate_chg | diff);
         valid_d = 1'b1;
      end else if (expstate_ack && expstate_valid) begin
         chg_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge BResetN) begin
      if (!BResetN) begin
         EXPSTATE       <= '0;
         expstate_chg   <= '0;
         expstate_valid <= 1'b0;
      end else begin
         EXPSTATE       <= TIE_EXPSTATE;
         expstate_chg   <= chg_d;
         expstate_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_mmio_irq_bridge.sv
// Self-checking bench for mmio_irq_bridge: per-cycle scoreboard against an
// input-history model plus directed pulse-shape and export-handshake checks.
module tb_mmio_irq_bridge;

   localparam int unsigned NUM_IRQ     = 8;
   localparam int unsigned EXP_W       = 32;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned STRETCH     = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_IRQ-1:0] mmio_irq = '0;
   logic [NUM_IRQ-1:0] edge_mode = '0;
   logic [NUM_IRQ-1:0] irq;
   logic [EXP_W-1:0]   tie = '0;
   logic [EXP_W-1:0]   expstate;
   logic [EXP_W-1:0]   chg;
   logic               valid;
   logic               ack = 1'b0;

   always #5 clk = ~clk;

   mmio_irq_bridge #(
      .NUM_IRQ     (NUM_IRQ),
      .EXP_W       (EXP_W),
      .SYNC_STAGES (SYNC_STAGES),
      .STRETCH     (STRETCH)
   ) dut (
      .CLK             (clk),
      .BResetN         (rst_n),
      .mmio_BInterrupt (mmio_irq),
      .cfg_edge_mode   (edge_mode),
      .BInterrupt      (irq),
      .TIE_EXPSTATE    (tie),
      .EXPSTATE        (expstate),
      .expstate_chg    (chg),
      .expstate_valid  (valid),
      .expstate_ack    (ack)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [NUM_IRQ-1:0] irq;
      logic [EXP_W-1:0]   st;
      logic [EXP_W-1:0]   chg;
      logic               val;
   } exp_t;

   // in_h[k-1] / mode_h[k-1]: inputs sampled at the k-th edge since reset release
   logic [NUM_IRQ-1:0] in_h[$];
   logic [NUM_IRQ-1:0] mode_h[$];
   exp_t               sb[$];
   logic [EXP_W-1:0]   m_exp = '0;
   logic [EXP_W-1:0]   m_chg = '0;
   logic               m_val = 1'b0;

   int run_len[NUM_IRQ];
   int last_run[NUM_IRQ];
   int rise_n[NUM_IRQ];

   function automatic logic in_at(int k, int ch);
      if (k < 1 || k > in_h.size()) return 1'b0;
      return in_h[k-1][ch];
   endfunction

   function automatic logic rise_at(int j, int ch);
      return in_at(j - SYNC_STAGES, ch) & ~in_at(j - SYNC_STAGES - 1, ch);
   endfunction

   // Edge mode: high iff a rise was seen within the last STRETCH edges with edge mode held since.
   function automatic logic model_irq(int n, int ch);
      if (!mode_h[n-1][ch]) return in_at(n - SYNC_STAGES, ch);
      for (int j = n; j >= 1 && j > n - int'(STRETCH); j--) begin
         if (!mode_h[j-1][ch]) return 1'b0;
         if (rise_at(j, ch)) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk) begin : monitor
      exp_t             e;
      int               n;
      logic [EXP_W-1:0] d;
      e = '0;
      n = 0;
      if (!rst_n) begin
         in_h.delete();
         mode_h.delete();
         m_exp = '0;
         m_chg = '0;
         m_val = 1'b0;
      end else begin
         in_h.push_back(mmio_irq);
         mode_h.push_back(edge_mode);
         n = in_h.size();
         for (int ch = 0; ch < NUM_IRQ; ch++) e.irq[ch] = model_irq(n, ch);
         d = tie ^ m_exp;
         if (d != '0 && ack) begin
            m_chg = d;
            m_val = 1'b1;
         end else if (d != '0) begin
            m_chg = m_chg | d;
            m_val = 1'b1;
         end else if (ack && m_val) begin
            m_chg = '0;
            m_val = 1'b0;
         end
         m_exp = tie;
         e.st  = m_exp;
         e.chg = m_chg;
         e.val = m_val;
      end
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check("sb_irq", 64'(irq), 64'(e.irq));
      check("sb_expstate", 64'(expstate), 64'(e.st));
      check("sb_chg", 64'(chg), 64'(e.chg));
      check("sb_valid", 64'(valid), 64'(e.val));
      for (int ch = 0; ch < NUM_IRQ; ch++) begin
         if (!rst_n) begin
            run_len[ch]  = 0;
            last_run[ch] = 0;
            rise_n[ch]   = 0;
         end else if (irq[ch]) begin
            if (run_len[ch] == 0) rise_n[ch] = n;
            run_len[ch]++;
         end else if (run_len[ch] != 0) begin
            last_run[ch] = run_len[ch];
            run_len[ch]  = 0;
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin : stim
      int n0;

      // Reset held with random inputs
      for (int i = 0; i < 6; i++) begin
         mmio_irq  = NUM_IRQ'($urandom);
         edge_mode = NUM_IRQ'($urandom);
         tie       = EXP_W'($urandom);
         step(1);
      end
      check("rst_irq", 64'(irq), 64'h0);
      check("rst_expstate", 64'(expstate), 64'h0);
      check("rst_chg", 64'(chg), 64'h0);
      check("rst_valid", 64'(valid), 64'h0);

      // Release with ch0 high in edge mode: exactly one pulse
      mmio_irq  = NUM_IRQ'(1);
      edge_mode = NUM_IRQ'(7);
      tie       = '0;
      rst_n     = 1'b1;
      step(12);
      check("rel_pulse_len", 64'(last_run[0]), 64'(STRETCH));
      check("rel_pulse_start", 64'(rise_n[0]), 64'(SYNC_STAGES + 1));
      mmio_irq[0] = 1'b0;
      step(4);

      // Level mode on ch3: held 10 cycles
      n0 = in_h.size();
      mmio_irq[3] = 1'b1;
      step(10);
      mmio_irq[3] = 1'b0;
      step(6);
      check("lvl_len", 64'(last_run[3]), 64'd10);
      check("lvl_start", 64'(rise_n[3]), 64'(n0 + SYNC_STAGES + 1));

      // Retrigger on ch1: second rise 4 cycles after the first, no gap
      mmio_irq[1] = 1'b1; step(2);
      mmio_irq[1] = 1'b0; step(2);
      mmio_irq[1] = 1'b1; step(2);
      mmio_irq[1] = 1'b0; step(12);
      check("retrig_len", 64'(last_run[1]), 64'(4 + STRETCH));

      // Edge->level switch on ch2 two cycles into a pulse, input already low
      mmio_irq[2] = 1'b1; step(2);
      mmio_irq[2] = 1'b0; step(2);
      edge_mode[2] = 1'b0;
      step(4);
      check("e2l_len", 64'(last_run[2]), 64'd2);

      // Level->edge switch with s high: output drops, no pulse
      mmio_irq[2] = 1'b1; step(5);
      edge_mode[2] = 1'b1; step(6);
      mmio_irq[2] = 1'b0; step(4);
      check("l2e_len", 64'(last_run[2]), 64'(5 - SYNC_STAGES));

      // Random traffic on ch4..7 and the export bus
      for (int i = 0; i < 25; i++) begin
         mmio_irq[7:4]  = 4'($urandom);
         edge_mode[7:4] = 4'($urandom);
         if ($urandom_range(1, 0) == 1) tie = EXP_W'($urandom);
         ack = 1'($urandom);
         step(1);
         ack = 1'b0;
         step(int'($urandom_range(2, 1)));
      end
      mmio_irq[7:4] = '0;

      // Export accumulate, ack, and ack collision
      tie = '0; step(2);
      ack = 1'b1; step(1);
      ack = 1'b0;
      tie = 32'h1; step(1);
      tie = 32'h3; step(1);
      check("acc_chg", 64'(chg), 64'h3);
      check("acc_valid", 64'(valid), 64'h1);
      ack = 1'b1; step(1);
      ack = 1'b0;
      check("ack_chg", 64'(chg), 64'h0);
      check("ack_valid", 64'(valid), 64'h0);
      tie = 32'h7;
      ack = 1'b1; step(1);
      ack = 1'b0;
      check("coll_chg", 64'(chg), 64'h4);
      check("coll_valid", 64'(valid), 64'h1);
      step(3);

      // Reset mid-pulse with a change pending; input stays high through release
      edge_mode[0] = 1'b1;
      mmio_irq[0]  = 1'b1;
      step(4);
      tie = 32'hA5;
      step(1);
      rst_n = 1'b0;
      #1;
      check("midrst_irq", 64'(irq), 64'h0);
      check("midrst_chg", 64'(chg), 64'h0);
      check("midrst_valid", 64'(valid), 64'h0);
      check("midrst_expstate", 64'(expstate), 64'h0);
      step(2);
      rst_n = 1'b1;
      step(12);
      check("rerel_pulse_len", 64'(last_run[0]), 64'(STRETCH));
      check("rerel_pulse_start", 64'(rise_n[0]), 64'(SYNC_STAGES + 1));
      mmio_irq[0] = 1'b0;
      step(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
